// File: rtl/cmd_frame_classifier_if.sv
// Control byte stream in, classified payload stream and command flags out.
interface cmd_frame_classifier_if;
  logic [7:0] con_din;
  logic       con_din_en;
  logic       con_bpi_en;
  logic       update_flag;
  logic       reconfig_flag;
  logic [7:0] con_dout;
  logic       con_dout_en;
  logic       con_dout_sof;
  logic       con_dout_eof;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output con_din, con_din_en, con_bpi_en,
    input  update_flag, reconfig_flag, con_dout, con_dout_en, con_dout_sof, con_dout_eof,
    input  frame_err, err_code
  );

  modport slave (
    input  con_din, con_din_en, con_bpi_en,
    output update_flag, reconfig_flag, con_dout, con_dout_en, con_dout_sof, con_dout_eof,
    output frame_err, err_code
  );
endinterface

// File: rtl/cmd_frame_classifier.sv
// Parses framed commands, raises sticky update/reconfig flags, forwards payload bytes with
// sof/eof marks and flags frames whose byte count disagrees with their length field.
module cmd_frame_classifier #(
  parameter logic [7:0]  CLASS_BYTE  = 8'h04,
  parameter logic [7:0]  OP_UPDATE   = 8'h20,
  parameter logic [7:0]  OP_RECONFIG = 8'h30,
  parameter int unsigned HDR_LEN     = 4,
  parameter int unsigned MAX_LEN     = 2048,
  parameter int unsigned CNT_W       = 12
) (
  input logic                   clk,
  input logic                   rst,
  cmd_frame_classifier_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrain} state_e;

  localparam logic [3:0] HdrLast      = 4'(HDR_LEN - 1);
  localparam logic [1:0] ErrShortHdr  = 2'd0;
  localparam logic [1:0] ErrShortPay  = 2'd1;
  localparam logic [1:0] ErrExcess    = 2'd2;
  localparam logic [1:0] ErrLenOver   = 2'd3;

  state_e           state_q, state_d;
  logic [3:0]       hdr_cnt_q, hdr_cnt_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic             discard_q, discard_d;
  logic             drain_chk_q, drain_chk_d;
  logic             upd_q, upd_d, rcf_q, rcf_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_en_q, dout_en_d, sof_q, sof_d, eof_q, eof_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic [15:0] len_now;
  logic        len_over, is_upd, is_rcf, fwd, pay_last;

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    byte0_d     = byte0_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    discard_d   = discard_q;
    drain_chk_d = drain_chk_q;
    upd_d       = upd_q;
    rcf_d       = rcf_q;
    dout_d      = 8'h00;
    dout_en_d   = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    code_d      = 2'd0;

    // The low length byte arrives at k=3, which may also be the last header byte.
    len_now  = (hdr_cnt_q == 4'd3) ? {len_q[15:8], bus.con_din} : len_q;
    len_over = (hdr_cnt_q == 4'd3) && (32'(len_now) > MAX_LEN);
    is_upd   = (byte0_q == CLASS_BYTE) && (bus.con_din == OP_UPDATE);
    is_rcf   = (byte0_q == CLASS_BYTE) && (bus.con_din == OP_RECONFIG);
    fwd      = ~discard_q & (upd_q | rcf_q);
    pay_last = (16'(pay_cnt_q) == len_q - 16'd1);

    if (bus.con_bpi_en) begin
      upd_d = 1'b0;
      rcf_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.con_din_en) begin
          byte0_d     = bus.con_din;
          hdr_cnt_d   = 4'd1;
          discard_d   = 1'b0;
          drain_chk_d = 1'b0;
          state_d     = StHdr;
        end
      end
      StHdr: begin
        if (!bus.con_din_en) begin
          err_d   = 1'b1;
          code_d  = ErrShortHdr;
          state_d = StIdle;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          // Opcode decode overrides a same-cycle con_bpi_en clear.
          if (hdr_cnt_q == 4'd1) begin
            upd_d     = is_upd;
            rcf_d     = is_rcf;
            discard_d = ~(is_upd | is_rcf);
          end
          if (hdr_cnt_q == 4'd2) len_d[15:8] = bus.con_din;
          if (hdr_cnt_q == 4'd3) len_d[7:0] = bus.con_din;
          if (len_over) begin
            err_d       = 1'b1;
            code_d      = ErrLenOver;
            drain_chk_d = 1'b0;
            state_d     = StDrain;
          end else if (hdr_cnt_q == HdrLast) begin
            pay_cnt_d = '0;
            if (len_now == 16'd0) begin
              drain_chk_d = 1'b1;
              state_d     = StDrain;
            end else begin
              state_d = StPayload;
            end
          end
        end
      end
      StPayload: begin
        if (!bus.con_din_en) begin
          err_d   = 1'b1;
          code_d  = ErrShortPay;
          state_d = StIdle;
        end else begin
          dout_en_d = fwd;
          dout_d    = fwd ? bus.con_din : 8'h00;
          sof_d     = fwd && (pay_cnt_q == '0);
          eof_d     = fwd && pay_last;
          if (pay_last) begin
            drain_chk_d = 1'b1;
            state_d     = StDrain;
          end else begin
            pay_cnt_d = pay_cnt_q + CNT_W'(1);
          end
        end
      end
      StDrain: begin
        if (!bus.con_din_en) begin
          state_d = StIdle;
        end else if (drain_chk_q) begin
          err_d       = 1'b1;
          code_d      = ErrExcess;
          drain_chk_d = 1'b0;
        end
      end
    endcase

    if (err_d) begin
      upd_d = 1'b0;
      rcf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hdr_cnt_q   <= 4'd0;
      byte0_q     <= 8'h00;
      len_q       <= 16'd0;
      pay_cnt_q   <= '0;
      discard_q   <= 1'b0;
      drain_chk_q <= 1'b0;
      upd_q       <= 1'b0;
      rcf_q       <= 1'b0;
      dout_q      <= 8'h00;
      dout_en_q   <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      byte0_q     <= byte0_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      discard_q   <= discard_d;
      drain_chk_q <= drain_chk_d;
      upd_q       <= upd_d;
      rcf_q       <= rcf_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign bus.update_flag   = upd_q;
  assign bus.reconfig_flag = rcf_q;
  assign bus.con_dout      = dout_q;
  assign bus.con_dout_en   = dout_en_q;
  assign bus.con_dout_sof  = sof_q;
  assign bus.con_dout_eof  = eof_q;
  assign bus.frame_err     = err_q;
  assign bus.err_code      = code_q;

endmodule
